// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-access stage.
//   state_t        - access sequencer states
//   F3_*           - func3 encodings for scalar loads/stores and matrix access
//   MATRIX_BEATS   - number of 32-bit beats in one 128-bit matrix access
//   is_misaligned  - alignment check for an access size / low address bits
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB     = 3'b000;
    localparam logic [2:0] F3_LH     = 3'b001;
    localparam logic [2:0] F3_LW     = 3'b010;
    localparam logic [2:0] F3_LBU    = 3'b100;
    localparam logic [2:0] F3_LHU    = 3'b101;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_SW     = 3'b010;
    localparam logic [2:0] F3_MATRIX = 3'b111;

    localparam int MATRIX_BEATS = 4;

    // Bytes are never misaligned; halves need an even address, words a
    // 4-byte boundary and matrix accesses a 16-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [3:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (f3 == F3_MATRIX) begin
            mis = (addr_lo != 4'h0);
        end else if (f3[1:0] == 2'b01) begin
            mis = addr_lo[0];
        end else if (f3[1:0] == 2'b10) begin
            mis = (addr_lo[1:0] != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// load_align_ext: selects the addressed byte/half of a loaded word and
// sign- or zero-extends it to 32 bits. Words pass through unchanged.
//   word    - raw 32-bit word read from memory
//   addr_lo - low two bits of the byte address
//   func3   - load size/sign encoding
//   data    - extended load result
module load_align_ext
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {addr_lo, 3'b000};
        data    = word;
        case (func3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  data = {24'h0, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  data = {16'h0, shifted[15:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage. Runs scalar loads/stores
// and 128-bit matrix loads/stores (four 32-bit beats) over a valid/ready
// data-memory port, stalling upstream while an access is in flight.
//   me_*            - EX/MEM register outputs (operation, address, data)
//   wb_fwd_data     - write-back value forwarded as scalar store data
//   dm_*            - data-memory request port (req/ready handshake)
//   mem_stall       - hold EX/MEM and earlier stages
//   mem_misalign    - one-cycle pulse when a misaligned access is dropped
//   mem_rdata       - extended scalar load result (valid in DONE)
//   mem_matrix_rdata- assembled matrix load result (valid in DONE)
//   mem_alu_o .. mem_w_select - combinational pass-through to MEM/WB
//
// state | meaning
// IDLE  | no access in flight; sample the presented op
// BUSY  | request beats on the memory port until the last one completes
// DONE  | results valid for one cycle; return to IDLE
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       me_regs_data2,
    input  logic [31:0]       me_alu_o,
    input  logic [127:0]      me_matrix_o,
    input  logic [4:0]        me_rd,
    input  logic              me_mem_read,
    input  logic              me_mem_write,
    input  logic              me_mem2reg,
    input  logic [1:0]        me_w_select,
    input  logic              me_rs2_r_select,
    input  logic [2:0]        me_func3_code,
    input  logic [31:0]       wb_fwd_data,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_wstrb,
    input  logic              dm_ready,
    input  logic [31:0]       dm_rdata,
    output logic              mem_stall,
    output logic              mem_misalign,
    output logic [31:0]       mem_rdata,
    output logic [127:0]      mem_matrix_rdata,
    output logic [31:0]       mem_alu_o,
    output logic [127:0]      mem_matrix_o,
    output logic [4:0]        mem_rd,
    output logic              mem_mem2reg,
    output logic [1:0]        mem_w_select
);

    state_t              state, state_next;
    logic [1:0]          beat;
    logic [ADDR_W-1:0]   base_addr;
    logic [2:0]          f3_r;
    logic                we_r;
    logic                mat_r;
    logic [127:0]        wdata_r;
    logic [3:0]          wstrb_r;
    logic [3:0][31:0]    rd_words;
    logic                misalign_r;

    logic                mem_op;
    logic                op_misaligned;
    logic                busy;
    logic                beat_done;
    logic                last_beat;
    logic [31:0]         store_src;
    logic [31:0]         store_lane;
    logic [3:0]          store_strb;
    logic [ADDR_W-1:0]   beat_addr;

    assign mem_op        = me_mem_read | me_mem_write;
    assign op_misaligned = is_misaligned(me_func3_code, me_alu_o[3:0]);
    assign busy          = (state == ST_BUSY);
    assign beat_done     = busy & dm_ready;
    assign last_beat     = mat_r ? (beat == 2'(MATRIX_BEATS - 1)) : 1'b1;

    // Scalar store data is lane-replicated so the strobes alone pick the byte/half.
    always_comb begin
        store_src  = me_rs2_r_select ? wb_fwd_data : me_regs_data2;
        store_lane = store_src;
        store_strb = 4'b1111;
        if (me_func3_code != F3_MATRIX) begin
            case (me_func3_code[1:0])
                2'b00: begin
                    store_lane = {4{store_src[7:0]}};
                    store_strb = 4'b0001 << me_alu_o[1:0];
                end
                2'b01: begin
                    store_lane = {2{store_src[15:0]}};
                    store_strb = 4'b0011 << me_alu_o[1:0];
                end
                default: begin
                    store_lane = store_src;
                    store_strb = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    mem_stall  = 1'b1;
                    state_next = op_misaligned ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_stall = 1'b1;
                if (beat_done && last_beat) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat       <= 2'd0;
            base_addr  <= '0;
            f3_r       <= 3'b000;
            we_r       <= 1'b0;
            mat_r      <= 1'b0;
            wdata_r    <= '0;
            wstrb_r    <= 4'b0000;
            rd_words   <= '0;
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= 1'b0;
            if (state == ST_IDLE && mem_op) begin
                base_addr  <= me_alu_o[ADDR_W-1:0];
                f3_r       <= me_func3_code;
                we_r       <= me_mem_write;
                mat_r      <= (me_func3_code == F3_MATRIX);
                wdata_r    <= (me_func3_code == F3_MATRIX) ? me_matrix_o : {96'h0, store_lane};
                wstrb_r    <= store_strb;
                beat       <= 2'd0;
                // Cleared so a dropped (misaligned) access reads back as zero.
                rd_words   <= '0;
                misalign_r <= op_misaligned;
            end else if (beat_done) begin
                if (!we_r) begin
                    rd_words[beat] <= dm_rdata;
                end
                beat <= beat + 2'd1;
            end
        end
    end

    assign beat_addr = {base_addr[ADDR_W-1:2], 2'b00} + {{(ADDR_W-4){1'b0}}, beat, 2'b00};

    // Port outputs decode from registered state only, so an async reset drops
    // the request at once and nothing shifts while waiting on dm_ready.
    assign dm_req   = busy;
    assign dm_we    = busy & we_r;
    assign dm_addr  = busy ? beat_addr : '0;
    assign dm_wdata = (busy && we_r) ? wdata_r[{beat, 5'b00000} +: 32] : 32'h0;
    assign dm_wstrb = (busy && we_r) ? wstrb_r : 4'b0000;

    assign mem_misalign     = misalign_r;
    assign mem_matrix_rdata = rd_words;

    load_align_ext u_load_align_ext (
        .word    (rd_words[0]),
        .addr_lo (base_addr[1:0]),
        .func3   (f3_r),
        .data    (mem_rdata)
    );

    assign mem_alu_o    = me_alu_o;
    assign mem_matrix_o = me_matrix_o;
    assign mem_rd       = me_rd;
    assign mem_mem2reg  = me_mem2reg;
    assign mem_w_select = me_w_select;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed, table-driven bench for mem_access_stage.
// Scalar accesses come from a vector table; matrix, wait-state, reset-abort
// and pass-through cases are hand-written sequences.
module tb_mem_access_stage;
    import mem_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  me_regs_data2;
    logic [31:0]  me_alu_o;
    logic [127:0] me_matrix_o;
    logic [4:0]   me_rd;
    logic         me_mem_read;
    logic         me_mem_write;
    logic         me_mem2reg;
    logic [1:0]   me_w_select;
    logic         me_rs2_r_select;
    logic [2:0]   me_func3_code;
    logic [31:0]  wb_fwd_data;
    logic         dm_req;
    logic         dm_we;
    logic [31:0]  dm_addr;
    logic [31:0]  dm_wdata;
    logic [3:0]   dm_wstrb;
    logic         dm_ready;
    logic [31:0]  dm_rdata;
    logic         mem_stall;
    logic         mem_misalign;
    logic [31:0]  mem_rdata;
    logic [127:0] mem_matrix_rdata;
    logic [31:0]  mem_alu_o;
    logic [127:0] mem_matrix_o;
    logic [4:0]   mem_rd;
    logic         mem_mem2reg;
    logic [1:0]   mem_w_select;

    logic [31:0]  mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[11:2]];

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .me_regs_data2    (me_regs_data2),
        .me_alu_o         (me_alu_o),
        .me_matrix_o      (me_matrix_o),
        .me_rd            (me_rd),
        .me_mem_read      (me_mem_read),
        .me_mem_write     (me_mem_write),
        .me_mem2reg       (me_mem2reg),
        .me_w_select      (me_w_select),
        .me_rs2_r_select  (me_rs2_r_select),
        .me_func3_code    (me_func3_code),
        .wb_fwd_data      (wb_fwd_data),
        .dm_req           (dm_req),
        .dm_we            (dm_we),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_wstrb         (dm_wstrb),
        .dm_ready         (dm_ready),
        .dm_rdata         (dm_rdata),
        .mem_stall        (mem_stall),
        .mem_misalign     (mem_misalign),
        .mem_rdata        (mem_rdata),
        .mem_matrix_rdata (mem_matrix_rdata),
        .mem_alu_o        (mem_alu_o),
        .mem_matrix_o     (mem_matrix_o),
        .mem_rd           (mem_rd),
        .mem_mem2reg      (mem_mem2reg),
        .mem_w_select     (mem_w_select)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic        sel;
        logic [31:0] fwd;
        logic [31:0] word;
        logic        mis;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [0:11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_op();
        me_mem_read     = 1'b0;
        me_mem_write    = 1'b0;
        me_rs2_r_select = 1'b0;
        me_func3_code   = 3'b000;
    endtask

    // Entered and left on a falling edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        mem[v.addr[11:2]] = v.word;
        dm_ready        = 1'b1;
        me_alu_o        = v.addr;
        me_func3_code   = v.f3;
        me_mem_read     = !v.wr;
        me_mem_write    = v.wr;
        me_regs_data2   = v.rs2;
        me_rs2_r_select = v.sel;
        wb_fwd_data     = v.fwd;
        #1;
        chk({v.name, " c0 stall"}, 128'(mem_stall), 128'(1'b1));
        chk({v.name, " c0 req"}, 128'(dm_req), 128'(1'b0));
        @(negedge clk);
        if (v.mis) begin
            chk({v.name, " req"}, 128'(dm_req), 128'(1'b0));
            chk({v.name, " misalign"}, 128'(mem_misalign), 128'(1'b1));
            chk({v.name, " stall"}, 128'(mem_stall), 128'(1'b0));
            chk({v.name, " rdata"}, 128'(mem_rdata), 128'(32'h0));
            clear_op();
            @(negedge clk);
            chk({v.name, " misalign once"}, 128'(mem_misalign), 128'(1'b0));
            chk({v.name, " req after"}, 128'(dm_req), 128'(1'b0));
        end else begin
            chk({v.name, " req"}, 128'(dm_req), 128'(1'b1));
            chk({v.name, " addr"}, 128'(dm_addr), 128'({v.addr[31:2], 2'b00}));
            chk({v.name, " we"}, 128'(dm_we), 128'(v.wr));
            chk({v.name, " c1 stall"}, 128'(mem_stall), 128'(1'b1));
            if (v.wr) begin
                chk({v.name, " wstrb"}, 128'(dm_wstrb), 128'(v.exp_strb));
                chk({v.name, " wdata"}, 128'(dm_wdata), 128'(v.exp_wdata));
            end
            @(negedge clk);
            chk({v.name, " c2 stall"}, 128'(mem_stall), 128'(1'b0));
            chk({v.name, " c2 req"}, 128'(dm_req), 128'(1'b0));
            if (!v.wr) begin
                chk({v.name, " rdata"}, 128'(mem_rdata), 128'(v.exp_rdata));
            end
            clear_op();
            @(negedge clk);
        end
    endtask

    // Matrix access; dm_ready is held low for 'waits' cycles on beat 'wait_beat'.
    task automatic run_matrix(input string name, input logic wr, input logic [127:0] mat,
                              input logic [31:0] base, input int wait_beat, input int waits,
                              input int exp_cycles);
        int nbeat;
        int wcnt;
        int done_c;
        logic [31:0] exp_addr;
        nbeat  = 0;
        wcnt   = 0;
        done_c = -1;
        if (!wr) begin
            for (int i = 0; i < 4; i++) begin
                mem[base[11:2] + 10'(i)] = mat[32*i +: 32];
            end
        end
        dm_ready      = 1'b1;
        me_alu_o      = base;
        me_matrix_o   = mat;
        me_func3_code = F3_MATRIX;
        me_mem_read   = !wr;
        me_mem_write  = wr;
        #1;
        chk({name, " c0 stall"}, 128'(mem_stall), 128'(1'b1));
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            if (!mem_stall && !dm_req) begin
                done_c = c;
                break;
            end
            if (dm_req) begin
                exp_addr = base + 32'(4 * nbeat);
                if (nbeat == wait_beat && wcnt < waits) begin
                    dm_ready = 1'b0;
                    wcnt++;
                end else begin
                    dm_ready = 1'b1;
                end
                chk({name, " addr"}, 128'(dm_addr), 128'(exp_addr));
                if (wr) begin
                    chk({name, " wdata"}, 128'(dm_wdata), 128'(mat[32*nbeat +: 32]));
                    chk({name, " wstrb"}, 128'(dm_wstrb), 128'(4'b1111));
                end
                if (dm_ready) nbeat++;
            end
        end
        dm_ready = 1'b1;
        chk({name, " done cycle"}, 128'(done_c), 128'(exp_cycles));
        chk({name, " beats"}, 128'(nbeat), 128'(4));
        if (!wr) begin
            chk({name, " rdata"}, mem_matrix_rdata, mat);
        end
        clear_op();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst             = 1'b1;
        me_regs_data2   = 32'h0;
        me_alu_o        = 32'h0;
        me_matrix_o     = 128'h0;
        me_rd           = 5'd0;
        me_mem2reg      = 1'b0;
        me_w_select     = 2'b00;
        wb_fwd_data     = 32'h0;
        dm_ready        = 1'b1;
        clear_op();

        //          name       f3      wr    addr          rs2           sel   fwd           word          mis   rdata         strb     wdata
        vecs[0]  = '{"lw",    F3_LW,  1'b0, 32'h0000_0100, 32'h0,        1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        vecs[1]  = '{"lb",    F3_LB,  1'b0, 32'h0000_0103, 32'h0,        1'b0, 32'h0,        32'h80FF_0000, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0};
        vecs[2]  = '{"lbu",   F3_LBU, 1'b0, 32'h0000_0103, 32'h0,        1'b0, 32'h0,        32'h80FF_0000, 1'b0, 32'h0000_0080, 4'b0000, 32'h0};
        vecs[3]  = '{"lh",    F3_LH,  1'b0, 32'h0000_0102, 32'h0,        1'b0, 32'h0,        32'h80FF_0000, 1'b0, 32'hFFFF_80FF, 4'b0000, 32'h0};
        vecs[4]  = '{"lhu",   F3_LHU, 1'b0, 32'h0000_0100, 32'h0,        1'b0, 32'h0,        32'h80FF_1234, 1'b0, 32'h0000_1234, 4'b0000, 32'h0};
        vecs[5]  = '{"lh_lo", F3_LH,  1'b0, 32'h0000_0100, 32'h0,        1'b0, 32'h0,        32'h0000_8001, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0};
        vecs[6]  = '{"lb_pos",F3_LB,  1'b0, 32'h0000_0107, 32'h0,        1'b0, 32'h0,        32'h7F00_0000, 1'b0, 32'h0000_007F, 4'b0000, 32'h0};
        vecs[7]  = '{"sh_fwd",F3_SH,  1'b1, 32'h0000_0102, 32'h5555_5555, 1'b1, 32'h1234_ABCD, 32'h0,        1'b0, 32'h0,        4'b1100, 32'hABCD_ABCD};
        vecs[8]  = '{"sb",    F3_SB,  1'b1, 32'h0000_0101, 32'h0000_00A5, 1'b0, 32'hFFFF_FFFF, 32'h0,        1'b0, 32'h0,        4'b0010, 32'hA5A5_A5A5};
        vecs[9]  = '{"sw",    F3_SW,  1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        4'b1111, 32'hCAFE_F00D};
        vecs[10] = '{"lw_mis",F3_LW,  1'b0, 32'h0000_0101, 32'h0,        1'b0, 32'h0,        32'h1111_1111, 1'b1, 32'h0,        4'b0000, 32'h0};
        vecs[11] = '{"lh_mis",F3_LH,  1'b0, 32'h0000_0103, 32'h0,        1'b0, 32'h0,        32'h2222_2222, 1'b1, 32'h0,        4'b0000, 32'h0};

        @(negedge clk);
        @(negedge clk);
        chk("rst dm_req", 128'(dm_req), 128'(1'b0));
        chk("rst dm_addr", 128'(dm_addr), 128'(32'h0));
        chk("rst dm_wdata", 128'(dm_wdata), 128'(32'h0));
        chk("rst dm_wstrb", 128'(dm_wstrb), 128'(4'b0000));
        chk("rst dm_we", 128'(dm_we), 128'(1'b0));
        chk("rst stall", 128'(mem_stall), 128'(1'b0));
        chk("rst misalign", 128'(mem_misalign), 128'(1'b0));
        chk("rst rdata", 128'(mem_rdata), 128'(32'h0));
        chk("rst mrdata", mem_matrix_rdata, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        // Non-memory op: pure pass-through, no stall.
        me_alu_o    = 32'h1234_5678;
        me_matrix_o = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        me_rd       = 5'd9;
        me_mem2reg  = 1'b1;
        me_w_select = 2'b10;
        #1;
        chk("alu stall", 128'(mem_stall), 128'(1'b0));
        chk("alu pass", 128'(mem_alu_o), 128'(32'h1234_5678));
        chk("mat pass", mem_matrix_o, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
        chk("rd pass", 128'(mem_rd), 128'(5'd9));
        chk("m2r pass", 128'(mem_mem2reg), 128'(1'b1));
        chk("wsel pass", 128'(mem_w_select), 128'(2'b10));
        @(negedge clk);
        chk("alu stall c1", 128'(mem_stall), 128'(1'b0));
        chk("alu req c1", 128'(dm_req), 128'(1'b0));
        me_mem2reg = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        run_matrix("mld_wait", 1'b0, 128'hA3A3_A3A3_B2B2_B2B2_C1C1_C1C1_D0D0_D0D0,
                   32'h0000_0200, 2, 2, 7);
        run_matrix("mld", 1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                   32'h0000_0240, 9, 0, 5);
        run_matrix("mst", 1'b1, 128'h4444_4444_3333_3333_2222_2222_1111_1111,
                   32'h0000_0280, 9, 0, 5);
        run_vec('{"mat_mis", F3_MATRIX, 1'b0, 32'h0000_0204, 32'h0, 1'b0, 32'h0,
                  32'h0, 1'b1, 32'h0, 4'b0000, 32'h0});

        // Reset while matrix beat 1 is presented.
        for (int i = 0; i < 4; i++) mem[10'h0C0 + 10'(i)] = 32'h5A5A_0000 + 32'(i);
        dm_ready      = 1'b1;
        me_alu_o      = 32'h0000_0300;
        me_func3_code = F3_MATRIX;
        me_mem_read   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid beat1 req", 128'(dm_req), 128'(1'b1));
        chk("rst_mid beat1 addr", 128'(dm_addr), 128'(32'h0000_0304));
        clear_op();
        #1 rst = 1'b1;
        #1;
        chk("rst_mid req drop", 128'(dm_req), 128'(1'b0));
        chk("rst_mid stall", 128'(mem_stall), 128'(1'b0));
        chk("rst_mid partial", mem_matrix_rdata, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage that sits directly downstream of the EX/MEM pipeline register and consumes its `me_*` outputs. It performs scalar RV32 loads and stores, and 128-bit matrix loads and stores as four 32-bit beats, over a valid/ready data-memory port. It stalls the upstream pipeline while an access is in flight. It presents load data, and passes the ALU and matrix results through, to the MEM/WB register.

## Interface
- `ADDR_W`, 32: data-memory byte-address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `me_regs_data2`  in  32  store data (rs2) from EX/MEM.
- `me_alu_o`  in  32  effective byte address, or ALU result for non-memory ops.
- `me_matrix_o`  in  128  matrix operand or result; store source for matrix stores.
- `me_rd`  in  5  destination register.
- `me_mem_read`, `me_mem_write`, `me_mem2reg`  in  1 each  memory-operation control.
- `me_w_select`  in  2  write-back source select; passed through.
- `me_rs2_r_select`  in  1  1 = use `wb_fwd_data` as scalar store data (WB→MEM forward).
- `me_func3_code`  in  3  access size and sign; 3'b111 = matrix access.
- `wb_fwd_data`  in  32  forwarded write-back value.
- `dm_req`  out  1  memory request valid.
- `dm_we`  out  1  write enable.
- `dm_addr`  out  ADDR_W  word-aligned address.
- `dm_wdata`  out  32  write data, lane-positioned.
- `dm_wstrb`  out  4  byte strobes.
- `dm_ready`  in  1  memory accepts or completes the beat.
- `dm_rdata`  in  32  read data; valid when `dm_req && dm_ready && !dm_we`.
- `mem_stall`  out  1  hold EX/MEM and all earlier stages.
- `mem_misalign`  out  1  one-cycle pulse: misaligned access dropped.
- `mem_rdata`  out  32  extended scalar load result.
- `mem_matrix_rdata`  out  128  assembled matrix load result.
- `mem_alu_o`, `mem_matrix_o`, `mem_rd`, `mem_mem2reg`, `mem_w_select`  out  —  combinational pass-through of the `me_*` equivalents.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, no memory op (`me_mem_read | me_mem_write` == 0):
  - no stall;
  - pass-through only.
- IDLE, memory op present:
  - capture address, size, read/write flag and store data into internal registers (scalar data from `wb_fwd_data` if `me_rs2_r_select`, else `me_regs_data2`; matrix data from `me_matrix_o`);
  - clear the beat counter;
  - go to BUSY;
  - `mem_stall` = 1 combinationally in this cycle.
- Misaligned op in IDLE: half on an odd address; word or matrix with `addr[1:0]` ≠ 0; matrix with `addr[3:0]` ≠ 0.
  - No request is issued. `mem_misalign` pulses the next cycle.
  - FSM goes to DONE. `mem_rdata` = 0.
- BUSY: `dm_req` = 1; `dm_addr` = base + 4 × beat. `dm_addr`, `dm_we`, `dm_wdata` and `dm_wstrb` hold stable until `dm_ready`. A request is never withdrawn.
- Beat completes when `dm_req && dm_ready`:
  - load beat: `dm_rdata` → word[beat];
  - beat counter increments;
  - after the last beat (1 scalar, 4 matrix) go to DONE.
- DONE: `mem_stall` = 0. Results are valid this cycle. Go to IDLE unconditionally. The still-presented op is not resampled, because EX/MEM advances on this edge.
- Store strobes:
  - SB: `4'b0001 << addr[1:0]`, data replicated to all byte lanes;
  - SH: `4'b0011 << addr[1:0]`;
  - SW and matrix: `4'b1111`.
- Load extension, in sub-module `load_align_ext`:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through;
  - byte or half selected by `addr[1:0]`.
- Matrix beat `i` carries bits `[32i+31:32i]`; beat 0 is at the lowest address.
- Reset values: state IDLE; `dm_req` 0, `dm_we` 0, `dm_addr` 0, `dm_wdata` 0, `dm_wstrb` 0; `mem_misalign` 0; `mem_rdata` 0; `mem_matrix_rdata` 0; beat counter 0. `mem_stall` resets to 0 (IDLE with no op).
- Reset mid-access aborts the access immediately (async): `dm_req` drops without waiting for `dm_ready`, and partial load data is discarded.

## Timing
- Scalar access, zero-wait memory: stall in cycles 0–1; results in cycle 2. Minimum 3 cycles per access.
- Matrix access, zero-wait memory: beats in cycles 1–4; DONE in cycle 5.
- Each wait state (`dm_ready` = 0) adds exactly one cycle.
- Non-memory ops: zero added latency; `mem_stall` stays 0.
- Back-to-back memory ops: the second op is sampled in the IDLE cycle after DONE, so the gap between accesses is 1 cycle.

## Structure
- Package `mem_pkg`:
  - state enum;
  - func3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW, `F3_MATRIX` = 3'b111);
  - `MATRIX_BEATS` = 4.
- Sub-module `load_align_ext`: combinational byte/half select and sign/zero extend.

## Test plan
- LW at 0x100, `dm_rdata` = 0xDEADBEEF, `dm_ready` tied to 1 → `dm_addr` = 0x100 in cycle 1; `mem_stall` high for cycles 0–1; `mem_rdata` = 0xDEADBEEF in cycle 2.
- LB at 0x103 with word 0x80FF_0000 → `mem_rdata` = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102, `me_rs2_r_select` = 1, `wb_fwd_data` = 0x1234ABCD → `dm_wstrb` = 4'b1100; `dm_wdata[31:16]` = 0xABCD.
- Matrix load at 0x200, `dm_ready` low for 2 cycles on beat 2 → addresses 0x200/0x204/0x208/0x20C in order; `dm_addr` stable while waiting; 128-bit result assembled with beat 0 in the LSBs; total 8 cycles.
- LW at 0x101 → no `dm_req`; `mem_misalign` pulses once; stall lasts 1 cycle.
- `rst` asserted during matrix beat 1 → `dm_req` = 0 and state IDLE immediately; a following LW completes normally.
